i2c_target_fifo: RTL
====================

Name: i2c_target_fifo

Overview:
Parametrised I2C target (slave) controller, successor to the single-byte I2C slave. It handles multi-byte write and read transfers, repeated START, and address masking/general call. Received and transmitted bytes are buffered in internal RX/TX FIFOs with valid/ready handshakes. Open-drain SDA/SCL drive, input synchronisers and optional clock stretching allow direct connection to the pads.

Parameters:
I2C_ADDRESS, 7'h49, target address.
ADDR_MASK, 7'h7F, address bits compared (1 = compare).
GENERAL_CALL_EN, 0, 1 = also accept address 7'h00 with write.
RX_DEPTH, 4, RX FIFO entries (power of 2, >=2).
TX_DEPTH, 4, TX FIFO entries (power of 2, >=2).
SYNC_STAGES, 2, flops on scl_in/sda_in (>=2).
STRETCH_EN, 1, 1 = hold SCL low when TX FIFO empty.

Ports:
clock  in  1  system clock.
reset_n  in  1  asynchronous, active-low reset.
scl_in  in  1  SCL pad input.
sda_in  in  1  SDA pad input.
scl_oe  out  1  1 = pull SCL low (stretch).
sda_oe  out  1  1 = pull SDA low.
rx_data  out  8  RX FIFO head byte.
rx_valid  out  1  RX FIFO not empty.
rx_ready  in  1  pop RX head when rx_valid & rx_ready.
tx_data  in  8  byte to send to controller.
tx_valid  in  1  push request.
tx_ready  out  1  TX FIFO not full; push when tx_valid & tx_ready.
addr_hit  out  1  1-cycle pulse on address match; rw in addr_rw.
addr_rw  out  1  R/W bit of last matched address (1 = controller reads).
stop_det  out  1  1-cycle pulse on STOP.
rx_overflow  out  1  1-cycle pulse, byte NACKed because RX FIFO full.
tx_underflow  out  1  1-cycle pulse, 0xFF sent because TX empty (STRETCH_EN=0).
busy  out  1  1 from START until STOP or IGNORE entry.

Behaviour:
- Reset: all outputs 0 except tx_ready=1. FIFOs empty, state IDLE, synchronisers set to 1 (bus idle high). Reset mid-transfer releases scl_oe/sda_oe immediately (async).
- Edge detection uses synchronised signals only. START = sda fall while scl high. STOP = sda rise while scl high.
- START (incl. repeated) or STOP in any state takes priority: partial byte discarded, sda_oe/scl_oe released next cycle. START -> ADDR; STOP -> IDLE with stop_det.
- Data sampled on scl rise; sda_oe changed only on scl fall, at most SYNC_STAGES+1 clocks after the pad edge. Requires clock >= 20x SCL rate.
- States:
  - IDLE -> ADDR on START.
  - ADDR: shift 8 bits MSB first. On 8th scl rise, evaluate match = ((addr ^ I2C_ADDRESS) & ADDR_MASK) == 0, or (GENERAL_CALL_EN & addr == 0 & rw == 0). Match -> ADDR_ACK with addr_hit; else IGNORE (sda never driven).
  - ADDR_ACK: sda_oe=1 from next scl fall to the following scl fall. Then rw=0 -> RX_DATA; rw=1 -> TX_LOAD.
  - RX_DATA: shift 8 bits. On 8th rise: if RX not full, push byte, -> RX_ACK (drive ACK); if full, drop byte, pulse rx_overflow, -> IGNORE (NACK by releasing).
  - RX_ACK: ACK slot as ADDR_ACK, then -> RX_DATA.
  - TX_LOAD (entered at scl fall, scl low): if TX not empty, pop into shift register, drive MSB, -> TX_DATA. If empty and STRETCH_EN, scl_oe=1 until not empty, then pop, drive MSB, release scl_oe one cycle later. If empty and !STRETCH_EN, load 0xFF, pulse tx_underflow.
  - TX_DATA: sda_oe = ~bit; shift on each scl fall; after 8th fall release sda -> TX_ACK.
  - TX_ACK: sample controller's ACK on scl rise. 0 -> TX_LOAD at next fall; 1 (NACK) -> IGNORE.
  - IGNORE: no drive; wait START/STOP.
- FIFOs: simultaneous push and pop both take effect, count unchanged. Push when full / pop when empty ignored. Pointers wrap modulo depth. rx_data is the head, valid same cycle as rx_valid.

Test Plan:
- Write 0x92 (addr 0x49 W), bytes 0xA5, 0x3C, STOP -> 3 ACKs; rx_data 0xA5 then 0x3C; addr_hit once, addr_rw=0; stop_det pulse; busy low after.
- Pre-load TX 0x81, 0x7E; read 0x93, controller ACK then NACK, STOP -> SDA bits 10000001 then 01111110; TX empty; state IDLE.
- Address 0x4A (W), ADDR_MASK=7'h7F -> no ACK, sda_oe never 1. Repeat with ADDR_MASK=7'h7C -> ACK.
- RX_DEPTH=2, rx_ready=0, write 3 bytes -> first 2 ACKed, 3rd NACKed, rx_overflow pulse, FIFO holds first two.
- Read with TX empty, STRETCH_EN=1 -> scl_oe held 1; push 0x55 after 500 clocks -> scl released, 0x55 sent. STRETCH_EN=0 -> 0xFF sent, tx_underflow pulse.
- Write 0x11, repeated START, read 0x93 -> 0x11 in RX, addr_hit twice with addr_rw 0 then 1. Also reset_n low mid-byte -> sda_oe/scl_oe 0 immediately, FIFOs empty.

Source files
------------

// File: rtl/i2c_target_fifo.sv
// i2c_target_fifo: I2C target controller with RX/TX byte FIFOs, address masking,
// general call, repeated START handling and optional SCL clock stretching.
// Ports:
//   clock, reset_n            system clock, asynchronous active-low reset
//   scl_in, sda_in            pad inputs (synchronised internally)
//   scl_oe, sda_oe            1 = pull the corresponding open-drain line low
//   rx_data/rx_valid/rx_ready RX FIFO head and pop handshake
//   tx_data/tx_valid/tx_ready TX FIFO push handshake
//   addr_hit, addr_rw         address-match pulse and R/W bit of last match
//   stop_det                  STOP pulse
//   rx_overflow               byte NACKed because the RX FIFO was full
//   tx_underflow              0xFF sent because the TX FIFO was empty
//   busy                      transfer in progress (START until STOP/IGNORE)
module i2c_target_fifo #(
    parameter logic [6:0] I2C_ADDRESS     = 7'h49,
    parameter logic [6:0] ADDR_MASK       = 7'h7F,
    parameter bit         GENERAL_CALL_EN = 1'b0,
    parameter int         RX_DEPTH        = 4,
    parameter int         TX_DEPTH        = 4,
    parameter int         SYNC_STAGES     = 2,
    parameter bit         STRETCH_EN      = 1'b1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       addr_hit,
    output logic       addr_rw,
    output logic       stop_det,
    output logic       rx_overflow,
    output logic       tx_underflow,
    output logic       busy
);
    localparam int RXW = $clog2(RX_DEPTH);
    localparam int TXW = $clog2(TX_DEPTH);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] ADDR     = 4'd1;
    localparam logic [3:0] ADDR_ACK = 4'd2;
    localparam logic [3:0] RX_DATA  = 4'd3;
    localparam logic [3:0] RX_ACK   = 4'd4;
    localparam logic [3:0] TX_LOAD  = 4'd5;
    localparam logic [3:0] TX_DATA  = 4'd6;
    localparam logic [3:0] TX_ACK   = 4'd7;
    localparam logic [3:0] IGNORE   = 4'd8;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s, scl_rise, scl_fall, start_c, stop_c;

    logic [3:0] state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       sda_oe_q, sda_oe_d, scl_oe_q, scl_oe_d;
    logic       ack_seen_q, ack_seen_d;
    logic       addr_rw_q, addr_rw_d;
    logic       addr_hit_q, addr_hit_d, stop_det_q, stop_det_d;
    logic       rx_ovf_q, rx_ovf_d, tx_unf_q, tx_unf_d;
    logic [7:0] byte_in;
    logic       match, load;

    logic [7:0]   rx_mem [RX_DEPTH];
    logic [RXW-1:0] rx_wr_q, rx_rd_q;
    logic [RXW:0]   rx_cnt_q;
    logic           rx_push, rx_pop, rx_full;

    logic [7:0]   tx_mem [TX_DEPTH];
    logic [TXW-1:0] tx_wr_q, tx_rd_q;
    logic [TXW:0]   tx_cnt_q;
    logic           tx_push, tx_pop, tx_empty;

    // Bus conditions are only ever derived from the synchronised copies.
    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s & scl_prev_q;
    assign start_c  = scl_s & scl_prev_q & ~sda_s & sda_prev_q;
    assign stop_c   = scl_s & scl_prev_q & sda_s & ~sda_prev_q;

    assign byte_in = {shift_q[6:0], sda_s};
    assign match   = (((byte_in[7:1] ^ I2C_ADDRESS) & ADDR_MASK) == 7'd0) ||
                     (GENERAL_CALL_EN && byte_in == 8'h00);

    assign rx_full  = rx_cnt_q == (RXW+1)'(RX_DEPTH);
    assign rx_valid = rx_cnt_q != '0;
    assign rx_data  = rx_mem[rx_rd_q];
    assign rx_pop   = rx_valid & rx_ready;

    assign tx_empty = tx_cnt_q == '0;
    assign tx_ready = tx_cnt_q != (TXW+1)'(TX_DEPTH);
    assign tx_push  = tx_valid & tx_ready;

    assign scl_oe       = scl_oe_q;
    assign sda_oe       = sda_oe_q;
    assign addr_hit     = addr_hit_q;
    assign addr_rw      = addr_rw_q;
    assign stop_det     = stop_det_q;
    assign rx_overflow  = rx_ovf_q;
    assign tx_underflow = tx_unf_q;
    assign busy         = (state_q != IDLE) && (state_q != IGNORE);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        sda_oe_d   = sda_oe_q;
        scl_oe_d   = 1'b0;
        ack_seen_d = ack_seen_q;
        addr_rw_d  = addr_rw_q;
        addr_hit_d = 1'b0;
        stop_det_d = 1'b0;
        rx_ovf_d   = 1'b0;
        tx_unf_d   = 1'b0;
        rx_push    = 1'b0;
        tx_pop     = 1'b0;
        load       = 1'b0;
        if (start_c) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_c) begin
            state_d    = IDLE;
            sda_oe_d   = 1'b0;
            stop_det_d = 1'b1;
        end else begin
            case (state_q)
                ADDR: if (scl_rise) begin
                    shift_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d    = match ? ADDR_ACK : IGNORE;
                        addr_hit_d = match;
                        addr_rw_d  = match ? byte_in[0] : addr_rw_q;
                    end
                end
                // First fall after the byte drives ACK, the next fall ends the slot.
                ADDR_ACK, RX_ACK: if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 3'd0;
                        load      = (state_q == ADDR_ACK) && addr_rw_q;
                        state_d   = load ? state_q : RX_DATA;
                    end
                end
                RX_DATA: if (scl_rise) begin
                    shift_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_push  = !rx_full;
                        rx_ovf_d = rx_full;
                        state_d  = rx_full ? IGNORE : RX_ACK;
                    end
                end
                TX_LOAD: load = 1'b1;
                TX_DATA: if (scl_fall) begin
                    if (bit_cnt_q == 3'd7) begin
                        sda_oe_d   = 1'b0;
                        ack_seen_d = 1'b0;
                        state_d    = TX_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {shift_q[6:0], 1'b0};
                        sda_oe_d  = ~shift_q[6];
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        state_d    = sda_s ? IGNORE : TX_ACK;
                        ack_seen_d = ~sda_s;
                    end
                    load = scl_fall & ack_seen_q;
                end
                IDLE, IGNORE: state_d = state_q;
                default: state_d = IDLE;
            endcase
            // Byte fetch for transmission; while stretching, SCL stays held for
            // the pop cycle and is released on the following clock.
            if (load) begin
                if (!tx_empty) begin
                    tx_pop    = 1'b1;
                    shift_d   = tx_mem[tx_rd_q];
                    sda_oe_d  = ~tx_mem[tx_rd_q][7];
                    bit_cnt_d = 3'd0;
                    scl_oe_d  = state_q == TX_LOAD;
                    state_d   = TX_DATA;
                end else if (STRETCH_EN) begin
                    sda_oe_d = 1'b0;
                    scl_oe_d = 1'b1;
                    state_d  = TX_LOAD;
                end else begin
                    shift_d   = 8'hFF;
                    sda_oe_d  = 1'b0;
                    bit_cnt_d = 3'd0;
                    tx_unf_d  = 1'b1;
                    state_d   = TX_DATA;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= IDLE;
            shift_q    <= 8'h00;
            bit_cnt_q  <= 3'd0;
            sda_oe_q   <= 1'b0;
            scl_oe_q   <= 1'b0;
            ack_seen_q <= 1'b0;
            addr_rw_q  <= 1'b0;
            addr_hit_q <= 1'b0;
            stop_det_q <= 1'b0;
            rx_ovf_q   <= 1'b0;
            tx_unf_q   <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            sda_oe_q   <= sda_oe_d;
            scl_oe_q   <= scl_oe_d;
            ack_seen_q <= ack_seen_d;
            addr_rw_q  <= addr_rw_d;
            addr_hit_q <= addr_hit_d;
            stop_det_q <= stop_det_d;
            rx_ovf_q   <= rx_ovf_d;
            tx_unf_q   <= tx_unf_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            rx_wr_q  <= rx_wr_q + RXW'(rx_push);
            rx_rd_q  <= rx_rd_q + RXW'(rx_pop);
            rx_cnt_q <= rx_cnt_q + (RXW+1)'(rx_push) - (RXW+1)'(rx_pop);
            tx_wr_q  <= tx_wr_q + TXW'(tx_push);
            tx_rd_q  <= tx_rd_q + TXW'(tx_pop);
            tx_cnt_q <= tx_cnt_q + (TXW+1)'(tx_push) - (TXW+1)'(tx_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (rx_push) rx_mem[rx_wr_q] <= byte_in;
        if (tx_push) tx_mem[tx_wr_q] <= tx_data;
    end
endmodule
